branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
Fetch-side branch predictor for the RV32E core: the speculating front end whose guesses are settled by the execute-stage branch decision.
- Fetch lookup: combinational read of a bimodal table of 2-bit saturating counters (BHT) plus a direct-mapped branch target buffer (BTB).
- Execute-stage resolve: trains both tables and raises a registered mispredict/redirect pulse for the PC unit.
- Flush: a sweep state machine invalidates the BTB (context switch, fence.i).

Parameters:
BHT_ENTRIES, 64, number of 2-bit counters; power of two, >=4
BTB_ENTRIES, 16, number of BTB entries; power of two, >=2

Ports:
clk  in  1  core clock
rst  in  1  reset, asynchronous, active-high
fetch_pc  in  32  PC being fetched; bits [1:0] ignored
pred_taken  out  1  predicted taken for fetch_pc (combinational)
pred_target  out  32  predicted target; valid only when pred_taken=1, else fetch_pc+4
resolve_valid  in  1  one resolved instruction this cycle
resolve_pc  in  32  PC of the resolved instruction
resolve_is_ctrl  in  1  instruction is a branch or jump
resolve_taken  in  1  actual taken (execute branch decision)
resolve_target  in  32  actual taken target
resolve_pred_taken  in  1  pred_taken carried down the pipe
resolve_pred_target  in  32  pred_target carried down the pipe
mispredict  out  1  one-cycle pulse, registered
redirect_pc  out  32  correct next PC; meaningful when mispredict=1
flush_req  in  1  start a BTB invalidate sweep
busy  out  1  sweep in progress

Behaviour:
- Reset state:
  - All BHT counters = 2'b01 (weakly not-taken); all BTB valid bits = 0.
  - mispredict=0, redirect_pc=0, busy=0, FSM in IDLE.
- Indexing:
  - BHT index = pc[$clog2(BHT_ENTRIES)+1:2].
  - BTB index = pc[$clog2(BTB_ENTRIES)+1:2].
  - BTB tag = pc[31:$clog2(BTB_ENTRIES)+2].
- Lookup (zero latency):
  - pred_taken = counter[1] & btb_valid & tag match & !busy.
  - pred_target = btb_target when pred_taken, else fetch_pc+4 (mod 2^32).
- Resolve, on a clk edge with resolve_valid=1 and busy=0:
  - Control instruction (resolve_is_ctrl=1):
    - Counter increments if taken, decrements if not; saturates at 3 and 0.
    - Taken: BTB entry written with {valid=1, tag, resolve_target}.
    - Not taken: BTB entry unchanged.
  - Non-control instruction (resolve_is_ctrl=0): no BHT update. If resolve_pred_taken=1 (aliasing), the BTB entry at that index is invalidated.
  - Mispredict condition: resolve_pred_taken != effective_taken, or both taken and resolve_pred_target != resolve_target. effective_taken = resolve_taken & resolve_is_ctrl.
  - Mispredict output: pulses on the following cycle with redirect_pc = effective_taken ? resolve_target : resolve_pc+4. It is a single cycle, with no hold.
- Same-cycle lookup and resolve to the same index: the lookup returns the pre-update value (no bypass). The update is visible on the next cycle.
- Sweep FSM, states IDLE and SWEEP, with a sweep pointer of $clog2(BTB_ENTRIES) bits:
  - IDLE -> SWEEP on flush_req; pointer=0 and busy=1 from the next cycle.
  - SWEEP clears one BTB valid bit per cycle. When pointer reaches BTB_ENTRIES-1 it returns to IDLE, so busy lasts exactly BTB_ENTRIES cycles.
  - flush_req during SWEEP is ignored; the sweep does not restart.
  - BHT is untouched by the sweep.
  - While busy: predictions are not-taken, resolves are neither trained nor checked, and mispredict stays 0.
- rst asserted mid-sweep or mid-pulse returns every output and table to reset values immediately.

Decomposition:
- Shared package (core package):
  - counter encoding constants: STRONG_NT=0, WEAK_NT=1, WEAK_T=2, STRONG_T=3
  - btb_entry_t struct {valid, tag, target}
  - sweep state enum
- Sub-module sat_counter2 (2-bit saturating update function/module), instantiated per update path.

Test Plan:
- Reset, then fetch_pc=0x100 -> pred_taken=0, pred_target=0x104.
- Resolve pc=0x100 ctrl taken target=0x40 with pred 0 -> next cycle mispredict=1, redirect_pc=0x40; then fetch 0x100 -> pred_taken=1, pred_target=0x40 (counter 01->10).
- Train 0x100 taken three times, then not-taken once -> counter 3->2, prediction still taken; a second not-taken -> prediction not-taken; 0->0 saturation checked by four further not-taken resolves.
- Resolve non-ctrl at 0x140, same BTB index as 0x100, with resolve_pred_taken=1 -> mispredict, redirect_pc=0x144, BTB entry invalidated, BHT counter unchanged.
- flush_req with BTB_ENTRIES=16 -> busy high exactly 16 cycles; pred_taken=0 throughout; a resolve during the sweep produces no mispredict; after the sweep every lookup misses.
- rst asserted during a sweep at pointer=5 -> busy=0 and mispredict=0 the same cycle, tables at reset values.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the fetch-side branch predictor.
package branch_predictor_pkg;

  // 2-bit saturating counter encoding; the MSB is the taken prediction.
  localparam logic [1:0] STRONG_NT = 2'd0;
  localparam logic [1:0] WEAK_NT   = 2'd1;
  localparam logic [1:0] WEAK_T    = 2'd2;
  localparam logic [1:0] STRONG_T  = 2'd3;

  // Tag field sized for the smallest legal BTB (2 entries -> pc[31:3]).
  // Larger BTBs store a zero-extended tag whose upper bits stay constant.
  localparam int TAG_FIELD_W = 29;

  typedef struct packed {
    logic                   valid;
    logic [TAG_FIELD_W-1:0] tag;
    logic [31:0]            target;
  } btb_entry_t;

  typedef enum logic {
    ST_IDLE,
    ST_SWEEP
  } sweep_state_e;

  // BTB tag of a PC: everything above the word offset and the index bits.
  function automatic logic [TAG_FIELD_W-1:0] btb_tag(input logic [31:0] pc, input int idx_w);
    return TAG_FIELD_W'(pc >> (idx_w + 2));
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch, resolve, redirect and flush signals between core and predictor.
interface branch_predictor_if;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_is_ctrl;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        resolve_pred_taken;
  logic [31:0] resolve_pred_target;

  logic        mispredict;
  logic [31:0] redirect_pc;

  logic        flush_req;
  logic        busy;

  // Core side: drives fetch/resolve/flush, consumes predictions and redirects.
  modport master (
    output fetch_pc, resolve_valid, resolve_pc, resolve_is_ctrl, resolve_taken,
           resolve_target, resolve_pred_taken, resolve_pred_target, flush_req,
    input  pred_taken, pred_target, mispredict, redirect_pc, busy
  );

  // Predictor side.
  modport slave (
    input  fetch_pc, resolve_valid, resolve_pc, resolve_is_ctrl, resolve_taken,
           resolve_target, resolve_pred_taken, resolve_pred_target, flush_req,
    output pred_taken, pred_target, mispredict, redirect_pc, busy
  );
endinterface

// File: rtl/sat_counter2.sv
// 2-bit saturating counter next-value logic.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt_i,
  input  logic       inc_i,
  output logic [1:0] cnt_o
);

  // Step toward the outcome, holding at the strong ends.
  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    cnt_o = cnt_i;
    if (inc_i) begin
      if (cnt_i != STRONG_T) cnt_o = cnt_i + 2'd1;
    end else begin
      if (cnt_i != STRONG_NT) cnt_o = cnt_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal BHT + direct-mapped BTB predictor with execute-stage training,
// registered mispredict/redirect and a one-entry-per-cycle BTB flush sweep.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 16
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);

  localparam int BHT_W = $clog2(BHT_ENTRIES);
  localparam int BTB_W = $clog2(BTB_ENTRIES);

  logic [1:0]             bht_q       [BHT_ENTRIES];
  logic [BTB_ENTRIES-1:0] btb_valid_q;
  logic [TAG_FIELD_W-1:0] btb_tag_q   [BTB_ENTRIES];
  logic [31:0]            btb_tgt_q   [BTB_ENTRIES];

  sweep_state_e     state_q, state_d;
  logic [BTB_W-1:0] ptr_q, ptr_d;
  logic             busy;

  logic             mispredict_q;
  logic [31:0]      redirect_q;

  // Fetch-side signals
  logic [BHT_W-1:0] f_bht_idx;
  logic [BTB_W-1:0] f_btb_idx;
  btb_entry_t       f_entry;
  logic             f_taken;

  // Resolve-side signals
  logic [BHT_W-1:0] r_bht_idx;
  logic [BTB_W-1:0] r_btb_idx;
  logic             fire, eff_taken, mispred;
  logic [1:0]       bht_cur, bht_nxt;

  assign f_bht_idx = bp.fetch_pc[BHT_W+1:2];
  assign f_btb_idx = bp.fetch_pc[BTB_W+1:2];
  assign r_bht_idx = bp.resolve_pc[BHT_W+1:2];
  assign r_btb_idx = bp.resolve_pc[BTB_W+1:2];

  // Zero-latency lookup from the current table contents (no resolve bypass).
  always_comb begin
    f_entry = '{valid:  btb_valid_q[f_btb_idx],
                tag:    btb_tag_q[f_btb_idx],
                target: btb_tgt_q[f_btb_idx]};
    f_taken = (bht_q[f_bht_idx] >= WEAK_T) && f_entry.valid &&
              (f_entry.tag == btb_tag(bp.fetch_pc, BTB_W)) && !busy;
  end

  assign bp.pred_taken  = f_taken;
  assign bp.pred_target = f_taken ? f_entry.target : bp.fetch_pc + 32'd4;

  // Resolves are ignored entirely while the sweep owns the BTB.
  assign fire      = bp.resolve_valid && !busy;
  assign eff_taken = bp.resolve_taken && bp.resolve_is_ctrl;
  assign mispred   = (bp.resolve_pred_taken != eff_taken) ||
                     (eff_taken && (bp.resolve_pred_target != bp.resolve_target));
  assign bht_cur   = bht_q[r_bht_idx];

  sat_counter2 u_bht_update (
    .cnt_i (bht_cur),
    .inc_i (bp.resolve_taken),
    .cnt_o (bht_nxt)
  );

  // BHT training on resolved control instructions.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= WEAK_NT;
    end else if (fire && bp.resolve_is_ctrl) begin
      bht_q[r_bht_idx] <= bht_nxt;
    end
  end

  // BTB valid bits: sweep clears, taken resolves set, aliasing non-control resolves clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_valid_q <= '0;
    end else if (busy) begin
      btb_valid_q[ptr_q] <= 1'b0;
    end else if (fire) begin
      if (eff_taken) begin
        btb_valid_q[r_btb_idx] <= 1'b1;
      end else if (!bp.resolve_is_ctrl && bp.resolve_pred_taken) begin
        btb_valid_q[r_btb_idx] <= 1'b0;
      end
    end
  end

  // BTB tag/target payload, written on taken control resolves.
  // NOTE: payload arrays carry no reset; the reset-cleared valid bit makes stale contents harmless.
  always_ff @(posedge clk) begin
    if (fire && eff_taken) begin
      btb_tag_q[r_btb_idx] <= btb_tag(bp.resolve_pc, BTB_W);
      btb_tgt_q[r_btb_idx] <= bp.resolve_target;
    end
  end

  // Single-cycle mispredict pulse with the corrected next PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
    end else begin
      mispredict_q <= fire && mispred;
      if (fire && mispred) redirect_q <= eff_taken ? bp.resolve_target : bp.resolve_pc + 32'd4;
    end
  end

  assign bp.mispredict  = mispredict_q;
  assign bp.redirect_pc = redirect_q;

  // Sweep FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Sweep FSM next state: one entry per cycle, flush requests ignored mid-sweep.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (bp.flush_req) begin
          state_d = ST_SWEEP;
          ptr_d   = '0;
        end
      end
      ST_SWEEP: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == BTB_W'(BTB_ENTRIES - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sweep FSM outputs.
  always_comb begin
    busy = (state_q == ST_SWEEP);
  end

  assign bp.busy = busy;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  branch_predictor_if bp_if ();

  branch_predictor #(
    .BHT_ENTRIES (64),
    .BTB_ENTRIES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic idle_inputs();
    bp_if.resolve_valid       = 1'b0;
    bp_if.resolve_pc          = '0;
    bp_if.resolve_is_ctrl     = 1'b0;
    bp_if.resolve_taken       = 1'b0;
    bp_if.resolve_target      = '0;
    bp_if.resolve_pred_taken  = 1'b0;
    bp_if.resolve_pred_target = '0;
    bp_if.flush_req           = 1'b0;
  endtask

  task automatic set_fetch(input logic [31:0] pc);
    @(negedge clk);
    bp_if.fetch_pc = pc;
    #1;
  endtask

  // One resolve through one clock edge; returns #1 after the edge so the pulse is visible.
  task automatic resolve(input logic [31:0] pc, input logic ctrl, input logic taken,
                         input logic [31:0] tgt, input logic ppt, input logic [31:0] ppg);
    @(negedge clk);
    bp_if.resolve_valid       = 1'b1;
    bp_if.resolve_pc          = pc;
    bp_if.resolve_is_ctrl     = ctrl;
    bp_if.resolve_taken       = taken;
    bp_if.resolve_target      = tgt;
    bp_if.resolve_pred_taken  = ppt;
    bp_if.resolve_pred_target = ppg;
    @(posedge clk);
    #1;
    bp_if.resolve_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bp_if.fetch_pc = 32'h100;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bp_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", bp_if.busy); end
    checks++; if (bp_if.mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict: got %0b want 0", bp_if.mispredict); end
    checks++; if (bp_if.redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect: got %h want 0", bp_if.redirect_pc); end
    checks++; if (bp_if.pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %0b want 0", bp_if.pred_taken); end
    checks++; if (bp_if.pred_target !== 32'h104) begin errors++; $display("FAIL reset_pred_target: got %h want 104", bp_if.pred_target); end
  endtask

  task automatic test_first_taken();
    resolve(32'h100, 1'b1, 1'b1, 32'h40, 1'b0, 32'h104);
    checks++; if (bp_if.mispredict !== 1'b1) begin errors++; $display("FAIL first_mispredict: got %0b want 1", bp_if.mispredict); end
    checks++; if (bp_if.redirect_pc !== 32'h40) begin errors++; $display("FAIL first_redirect: got %h want 40", bp_if.redirect_pc); end
    @(posedge clk); #1;
    checks++; if (bp_if.mispredict !== 1'b0) begin errors++; $display("FAIL pulse_width: got %0b want 0", bp_if.mispredict); end
    set_fetch(32'h100);
    checks++; if (bp_if.pred_taken !== 1'b1) begin errors++; $display("FAIL first_pred_taken: got %0b want 1", bp_if.pred_taken); end
    checks++; if (bp_if.pred_target !== 32'h40) begin errors++; $display("FAIL first_pred_target: got %h want 40", bp_if.pred_target); end
    // Same BTB and BHT index, different tag: must miss.
    set_fetch(32'h500);
    checks++; if (bp_if.pred_taken !== 1'b0) begin errors++; $display("FAIL tag_miss_taken: got %0b want 0", bp_if.pred_taken); end
    checks++; if (bp_if.pred_target !== 32'h504) begin errors++; $display("FAIL tag_miss_target: got %h want 504", bp_if.pred_target); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      resolve(32'h100, 1'b1, 1'b1, 32'h40, 1'b1, 32'h40);
      checks++; if (bp_if.mispredict !== 1'b0) begin errors++; $display("FAIL train_taken_%0d: mispredict got %0b want 0", i, bp_if.mispredict); end
    end
    // Counter 3 -> 2: still taken.
    resolve(32'h100, 1'b1, 1'b0, 32'h40, 1'b1, 32'h40);
    checks++; if (bp_if.mispredict !== 1'b1) begin errors++; $display("FAIL nt1_mispredict: got %0b want 1", bp_if.mispredict); end
    checks++; if (bp_if.redirect_pc !== 32'h104) begin errors++; $display("FAIL nt1_redirect: got %h want 104", bp_if.redirect_pc); end
    set_fetch(32'h100);
    checks++; if (bp_if.pred_taken !== 1'b1) begin errors++; $display("FAIL nt1_pred: got %0b want 1", bp_if.pred_taken); end
    // Counter 2 -> 1: not taken.
    resolve(32'h100, 1'b1, 1'b0, 32'h40, 1'b1, 32'h40);
    checks++; if (bp_if.mispredict !== 1'b1) begin errors++; $display("FAIL nt2_mispredict: got %0b want 1", bp_if.mispredict); end
    set_fetch(32'h100);
    checks++; if (bp_if.pred_taken !== 1'b0) begin errors++; $display("FAIL nt2_pred: got %0b want 0", bp_if.pred_taken); end
    checks++; if (bp_if.pred_target !== 32'h104) begin errors++; $display("FAIL nt2_target: got %h want 104", bp_if.pred_target); end
    // Counter 1 -> 0 -> 0 -> 0 -> 0.
    for (int i = 0; i < 4; i++) begin
      resolve(32'h100, 1'b1, 1'b0, 32'h40, 1'b0, 32'h104);
      checks++; if (bp_if.mispredict !== 1'b0) begin errors++; $display("FAIL sat0_mispredict_%0d: got %0b want 0", i, bp_if.mispredict); end
      set_fetch(32'h100);
      checks++; if (bp_if.pred_taken !== 1'b0) begin errors++; $display("FAIL sat0_pred_%0d: got %0b want 0", i, bp_if.pred_taken); end
    end
    // 0 -> 1: still not taken, proving the counter held at 0.
    resolve(32'h100, 1'b1, 1'b1, 32'h40, 1'b0, 32'h104);
    checks++; if (bp_if.mispredict !== 1'b1) begin errors++; $display("FAIL up1_mispredict: got %0b want 1", bp_if.mispredict); end
    checks++; if (bp_if.redirect_pc !== 32'h40) begin errors++; $display("FAIL up1_redirect: got %h want 40", bp_if.redirect_pc); end
    set_fetch(32'h100);
    checks++; if (bp_if.pred_taken !== 1'b0) begin errors++; $display("FAIL up1_pred: got %0b want 0", bp_if.pred_taken); end
    // 1 -> 2: taken again.
    resolve(32'h100, 1'b1, 1'b1, 32'h40, 1'b0, 32'h104);
    set_fetch(32'h100);
    checks++; if (bp_if.pred_taken !== 1'b1) begin errors++; $display("FAIL up2_pred: got %0b want 1", bp_if.pred_taken); end
    // Direction right, target wrong -> mispredict; counter 2 -> 3, BTB retargeted.
    resolve(32'h100, 1'b1, 1'b1, 32'h80, 1'b1, 32'h40);
    checks++; if (bp_if.mispredict !== 1'b1) begin errors++; $display("FAIL tgt_mispredict: got %0b want 1", bp_if.mispredict); end
    checks++; if (bp_if.redirect_pc !== 32'h80) begin errors++; $display("FAIL tgt_redirect: got %h want 80", bp_if.redirect_pc); end
    set_fetch(32'h100);
    checks++; if (bp_if.pred_taken !== 1'b1) begin errors++; $display("FAIL tgt_pred: got %0b want 1", bp_if.pred_taken); end
    checks++; if (bp_if.pred_target !== 32'h80) begin errors++; $display("FAIL tgt_target: got %h want 80", bp_if.pred_target); end
  endtask

  task automatic test_alias();
    // Non-control at 0x140 shares BTB index 0 with 0x100; taken bit must be masked.
    resolve(32'h140, 1'b0, 1'b1, 32'h999, 1'b1, 32'h80);
    checks++; if (bp_if.mispredict !== 1'b1) begin errors++; $display("FAIL alias_mispredict: got %0b want 1", bp_if.mispredict); end
    checks++; if (bp_if.redirect_pc !== 32'h144) begin errors++; $display("FAIL alias_redirect: got %h want 144", bp_if.redirect_pc); end
    set_fetch(32'h100);
    checks++; if (bp_if.pred_taken !== 1'b0) begin errors++; $display("FAIL alias_inval_pred: got %0b want 0", bp_if.pred_taken); end
    checks++; if (bp_if.pred_target !== 32'h104) begin errors++; $display("FAIL alias_inval_target: got %h want 104", bp_if.pred_target); end
    // BHT[0x10] untouched at 1; one taken resolve makes it 2 (taken).
    resolve(32'h140, 1'b1, 1'b1, 32'h200, 1'b0, 32'h144);
    checks++; if (bp_if.redirect_pc !== 32'h200) begin errors++; $display("FAIL alias_train_redirect: got %h want 200", bp_if.redirect_pc); end
    set_fetch(32'h140);
    checks++; if (bp_if.pred_taken !== 1'b1) begin errors++; $display("FAIL alias_bht_kept: got %0b want 1", bp_if.pred_taken); end
    checks++; if (bp_if.pred_target !== 32'h200) begin errors++; $display("FAIL alias_train_target: got %h want 200", bp_if.pred_target); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk);
    bp_if.fetch_pc            = 32'h140;
    bp_if.resolve_valid       = 1'b1;
    bp_if.resolve_pc          = 32'h140;
    bp_if.resolve_is_ctrl     = 1'b1;
    bp_if.resolve_taken       = 1'b0;
    bp_if.resolve_target      = 32'h0;
    bp_if.resolve_pred_taken  = 1'b1;
    bp_if.resolve_pred_target = 32'h200;
    #1;
    checks++; if (bp_if.pred_taken !== 1'b1) begin errors++; $display("FAIL same_cycle_pre_pred: got %0b want 1", bp_if.pred_taken); end
    checks++; if (bp_if.pred_target !== 32'h200) begin errors++; $display("FAIL same_cycle_pre_target: got %h want 200", bp_if.pred_target); end
    @(posedge clk); #1;
    bp_if.resolve_valid = 1'b0;
    checks++; if (bp_if.pred_taken !== 1'b0) begin errors++; $display("FAIL same_cycle_post_pred: got %0b want 0", bp_if.pred_taken); end
    checks++; if (bp_if.pred_target !== 32'h144) begin errors++; $display("FAIL same_cycle_post_target: got %h want 144", bp_if.pred_target); end
    checks++; if (bp_if.mispredict !== 1'b1) begin errors++; $display("FAIL same_cycle_mispredict: got %0b want 1", bp_if.mispredict); end
    checks++; if (bp_if.redirect_pc !== 32'h144) begin errors++; $display("FAIL same_cycle_redirect: got %h want 144", bp_if.redirect_pc); end
  endtask

  task automatic test_flush();
    int busy_cycles;
    // Counter for 0x104 (BHT 1, BTB 1): 1 -> 2 -> 3.
    resolve(32'h104, 1'b1, 1'b1, 32'h300, 1'b0, 32'h108);
    resolve(32'h104, 1'b1, 1'b1, 32'h300, 1'b1, 32'h300);
    set_fetch(32'h104);
    checks++; if (bp_if.pred_taken !== 1'b1) begin errors++; $display("FAIL flush_setup_pred: got %0b want 1", bp_if.pred_taken); end
    @(negedge clk);
    bp_if.flush_req = 1'b1;
    @(posedge clk); #1;
    bp_if.flush_req = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bp_if.busy !== 1'b1) break;
      busy_cycles++;
      checks++; if (bp_if.pred_taken !== 1'b0) begin errors++; $display("FAIL sweep_pred_%0d: got %0b want 0", busy_cycles, bp_if.pred_taken); end
      checks++; if (bp_if.mispredict !== 1'b0) begin errors++; $display("FAIL sweep_mispredict_%0d: got %0b want 0", busy_cycles, bp_if.mispredict); end
      // Two not-taken resolves that would mispredict and train if not blocked.
      bp_if.resolve_valid       = (busy_cycles == 3) || (busy_cycles == 4);
      bp_if.resolve_pc          = 32'h104;
      bp_if.resolve_is_ctrl     = 1'b1;
      bp_if.resolve_taken       = 1'b0;
      bp_if.resolve_pred_taken  = 1'b1;
      bp_if.resolve_pred_target = 32'h300;
      bp_if.flush_req           = (busy_cycles == 6);
    end
    idle_inputs();
    checks++; if (busy_cycles != 16) begin errors++; $display("FAIL sweep_length: got %0d cycles want 16", busy_cycles); end
    set_fetch(32'h104);
    checks++; if (bp_if.pred_taken !== 1'b0) begin errors++; $display("FAIL post_sweep_pred_104: got %0b want 0", bp_if.pred_taken); end
    checks++; if (bp_if.pred_target !== 32'h108) begin errors++; $display("FAIL post_sweep_target_104: got %h want 108", bp_if.pred_target); end
    set_fetch(32'h140);
    checks++; if (bp_if.pred_taken !== 1'b0) begin errors++; $display("FAIL post_sweep_pred_140: got %0b want 0", bp_if.pred_taken); end
    // BHT[1] still 3: taken keeps 3, one not-taken gives 2, still taken.
    resolve(32'h104, 1'b1, 1'b1, 32'h300, 1'b0, 32'h108);
    checks++; if (bp_if.mispredict !== 1'b1) begin errors++; $display("FAIL post_sweep_mispredict: got %0b want 1", bp_if.mispredict); end
    resolve(32'h104, 1'b1, 1'b0, 32'h0, 1'b1, 32'h300);
    checks++; if (bp_if.redirect_pc !== 32'h108) begin errors++; $display("FAIL post_sweep_redirect: got %h want 108", bp_if.redirect_pc); end
    set_fetch(32'h104);
    checks++; if (bp_if.pred_taken !== 1'b1) begin errors++; $display("FAIL bht_survives_sweep: got %0b want 1", bp_if.pred_taken); end
    checks++; if (bp_if.pred_target !== 32'h300) begin errors++; $display("FAIL bht_survives_target: got %h want 300", bp_if.pred_target); end
  endtask

  task automatic test_reset_mid_sweep();
    // Counter for 0x120 (BHT 8, BTB 8): 1 -> 2 -> 3; BTB 8 valid.
    resolve(32'h120, 1'b1, 1'b1, 32'h500, 1'b0, 32'h124);
    resolve(32'h120, 1'b1, 1'b1, 32'h500, 1'b1, 32'h500);
    set_fetch(32'h120);
    checks++; if (bp_if.pred_taken !== 1'b1) begin errors++; $display("FAIL mid_setup_pred: got %0b want 1", bp_if.pred_taken); end
    @(negedge clk);
    bp_if.flush_req = 1'b1;
    @(posedge clk); #1;
    bp_if.flush_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++; if (bp_if.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %0b want 0", bp_if.busy); end
    checks++; if (bp_if.mispredict !== 1'b0) begin errors++; $display("FAIL mid_rst_mispredict: got %0b want 0", bp_if.mispredict); end
    checks++; if (bp_if.redirect_pc !== 32'h0) begin errors++; $display("FAIL mid_rst_redirect: got %h want 0", bp_if.redirect_pc); end
    checks++; if (bp_if.pred_taken !== 1'b0) begin errors++; $display("FAIL mid_rst_pred: got %0b want 0", bp_if.pred_taken); end
    @(negedge clk);
    rst = 1'b0;
    set_fetch(32'h120);
    checks++; if (bp_if.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_stays_idle: got %0b want 0", bp_if.busy); end
    checks++; if (bp_if.pred_target !== 32'h124) begin errors++; $display("FAIL mid_rst_btb_cleared: got %h want 124", bp_if.pred_target); end
    // BHT[8] back at 1: taken -> 2 (taken), not-taken -> 1 (not taken).
    resolve(32'h120, 1'b1, 1'b1, 32'h500, 1'b0, 32'h124);
    checks++; if (bp_if.mispredict !== 1'b1) begin errors++; $display("FAIL mid_rst_train_mispredict: got %0b want 1", bp_if.mispredict); end
    checks++; if (bp_if.redirect_pc !== 32'h500) begin errors++; $display("FAIL mid_rst_train_redirect: got %h want 500", bp_if.redirect_pc); end
    set_fetch(32'h120);
    checks++; if (bp_if.pred_taken !== 1'b1) begin errors++; $display("FAIL mid_rst_train_pred: got %0b want 1", bp_if.pred_taken); end
    resolve(32'h120, 1'b1, 1'b0, 32'h0, 1'b1, 32'h500);
    checks++; if (bp_if.redirect_pc !== 32'h124) begin errors++; $display("FAIL mid_rst_nt_redirect: got %h want 124", bp_if.redirect_pc); end
    set_fetch(32'h120);
    checks++; if (bp_if.pred_taken !== 1'b0) begin errors++; $display("FAIL bht_reset_value: got %0b want 0", bp_if.pred_taken); end
  endtask

  initial begin
    test_reset();
    test_first_taken();
    test_saturation();
    test_alias();
    test_same_cycle();
    test_flush();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
